// File: rtl/raster_pkg.sv
// Shared widths, scan FSM encoding and small min/max helpers for the
// triangle rasterizer.
package raster_pkg;
    localparam int COORD_W = 12;
    localparam int DEPTH_W = 21;
    localparam int COLOR_W = 24;
    localparam int EDGE_W  = 27;
    localparam int DIFF_W  = COORD_W + 1;
    localparam int PROD_W  = 2 * DIFF_W;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SCAN,
        DRAIN,
        DONE
    } rs_state_t;

    function automatic logic [COORD_W-1:0] min3_c(input logic [COORD_W-1:0] a,
                                                  input logic [COORD_W-1:0] b,
                                                  input logic [COORD_W-1:0] c);
        logic [COORD_W-1:0] m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    function automatic logic [COORD_W-1:0] max3_c(input logic [COORD_W-1:0] a,
                                                  input logic [COORD_W-1:0] b,
                                                  input logic [COORD_W-1:0] c);
        logic [COORD_W-1:0] m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic logic [DEPTH_W-1:0] min3_d(input logic [DEPTH_W-1:0] a,
                                                  input logic [DEPTH_W-1:0] b,
                                                  input logic [DEPTH_W-1:0] c);
        logic [DEPTH_W-1:0] m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction
endpackage

// File: rtl/edge_eval.sv
// One edge function E = (bx-ax)(py-ay) - (by-ay)(px-ax), fully combinational.
// Evaluated at the third vertex it yields the triangle's signed area.
module edge_eval
    import raster_pkg::*;
(
    input  logic [COORD_W-1:0]       ax,
    input  logic [COORD_W-1:0]       ay,
    input  logic [COORD_W-1:0]       bx,
    input  logic [COORD_W-1:0]       by,
    input  logic [COORD_W-1:0]       px,
    input  logic [COORD_W-1:0]       py,
    output logic signed [EDGE_W-1:0] e
);
    logic signed [DIFF_W-1:0] dx_ab, dy_ab, dx_ap, dy_ap;
    logic signed [PROD_W-1:0] p0, p1;

    always_comb begin
        dx_ab = $signed({1'b0, bx}) - $signed({1'b0, ax});
        dy_ab = $signed({1'b0, by}) - $signed({1'b0, ay});
        dx_ap = $signed({1'b0, px}) - $signed({1'b0, ax});
        dy_ap = $signed({1'b0, py}) - $signed({1'b0, ay});
        p0    = PROD_W'(dx_ab) * PROD_W'(dy_ap);
        p1    = PROD_W'(dy_ab) * PROD_W'(dx_ap);
        e     = EDGE_W'(p0) - EDGE_W'(p1);
    end
endmodule

// File: rtl/raster_scan.sv
// Triangle rasterizer: latch a triangle, set up a clamped bounding box and
// signed area, scan it in raster order and stream covered pixels out.
module raster_scan
    import raster_pkg::*;
#(
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vertice_ready,
    input  logic [COORD_W-1:0] vertice1_x,
    input  logic [COORD_W-1:0] vertice1_y,
    input  logic [DEPTH_W-1:0] vertice1_depth,
    input  logic [COLOR_W-1:0] vertice1_color,
    input  logic [COORD_W-1:0] vertice2_x,
    input  logic [COORD_W-1:0] vertice2_y,
    input  logic [DEPTH_W-1:0] vertice2_depth,
    input  logic [COLOR_W-1:0] vertice2_color,
    input  logic [COORD_W-1:0] vertice3_x,
    input  logic [COORD_W-1:0] vertice3_y,
    input  logic [DEPTH_W-1:0] vertice3_depth,
    input  logic [COLOR_W-1:0] vertice3_color,
    output logic               get_next_triangle,
    output logic               busy,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic [DEPTH_W-1:0] pix_depth,
    output logic [COLOR_W-1:0] pix_color
);
    localparam logic [COORD_W-1:0] X_LIM  = COORD_W'(SCREEN_W);
    localparam logic [COORD_W-1:0] Y_LIM  = COORD_W'(SCREEN_H);
    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(SCREEN_W - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(SCREEN_H - 1);

    rs_state_t state, state_nxt;

    logic [2:0][COORD_W-1:0] vx, vy;
    logic [2:0][DEPTH_W-1:0] vd;
    logic [2:0][COLOR_W-1:0] vc;

    logic [COORD_W-1:0] xmin, xmax, ymax, cx, cy;
    logic [DEPTH_W-1:0] zflat;
    logic               area_pos;

    logic [2:0][COORD_W-1:0] px, py;
    logic [2:0][EDGE_W-1:0]  ev;
    logic [COORD_W-1:0]      vmin_x, vmax_x, vmin_y, vmax_y;
    logic                    degenerate, covered, advance, last_pos;
    logic [2:0]              e_neg, e_zero;
    logic                    unused_colors;

    assign unused_colors = ^{vc[2], vc[1]};

    // Instance 0 looks at v3 during SETUP, which makes its result the area.
    always_comb begin
        px = {3{cx}};
        py = {3{cy}};
        if (state == SETUP) begin
            px[0] = vx[2];
            py[0] = vy[2];
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_edge
        edge_eval u_edge (
            .ax(vx[i]),
            .ay(vy[i]),
            .bx(vx[(i+1)%3]),
            .by(vy[(i+1)%3]),
            .px(px[i]),
            .py(py[i]),
            .e (ev[i])
        );
        assign e_neg[i]  = ev[i][EDGE_W-1];
        assign e_zero[i] = (ev[i] == '0);
    end

    assign vmin_x = min3_c(vx[0], vx[1], vx[2]);
    assign vmax_x = max3_c(vx[0], vx[1], vx[2]);
    assign vmin_y = min3_c(vy[0], vy[1], vy[2]);
    assign vmax_y = max3_c(vy[0], vy[1], vy[2]);

    assign degenerate = e_zero[0] || (vmin_x >= X_LIM) || (vmin_y >= Y_LIM);
    // Inclusive edges: zero counts as inside for either winding.
    assign covered    = area_pos ? ~|e_neg : &(e_neg | e_zero);
    assign advance    = !pix_valid || pix_ready;
    assign last_pos   = (cx == xmax) && (cy == ymax);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt         = state;
        get_next_triangle = 1'b0;
        busy              = (state != IDLE);
        case (state)
            IDLE:    if (vertice_ready) state_nxt = SETUP;
            SETUP:   state_nxt = degenerate ? DONE : SCAN;
            SCAN:    if (advance && last_pos) state_nxt = DRAIN;
            DRAIN:   if (advance) state_nxt = DONE;
            DONE: begin
                state_nxt         = IDLE;
                get_next_triangle = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vx        <= '0;
            vy        <= '0;
            vd        <= '0;
            vc        <= '0;
            xmin      <= '0;
            xmax      <= '0;
            ymax      <= '0;
            cx        <= '0;
            cy        <= '0;
            zflat     <= '0;
            area_pos  <= 1'b0;
            pix_valid <= 1'b0;
            pix_x     <= '0;
            pix_y     <= '0;
            pix_depth <= '0;
            pix_color <= '0;
        end else begin
            if (state == IDLE && vertice_ready) begin
                vx <= {vertice3_x, vertice2_x, vertice1_x};
                vy <= {vertice3_y, vertice2_y, vertice1_y};
                vd <= {vertice3_depth, vertice2_depth, vertice1_depth};
                vc <= {vertice3_color, vertice2_color, vertice1_color};
            end

            if (state == SETUP) begin
                xmin     <= vmin_x;
                xmax     <= (vmax_x > X_LAST) ? X_LAST : vmax_x;
                ymax     <= (vmax_y > Y_LAST) ? Y_LAST : vmax_y;
                cx       <= vmin_x;
                cy       <= vmin_y;
                area_pos <= ~e_neg[0];
                zflat    <= min3_d(vd[0], vd[1], vd[2]);
            end

            if (pix_valid && pix_ready) pix_valid <= 1'b0;

            if (state == SCAN && advance) begin
                pix_valid <= covered;
                if (covered) begin
                    pix_x     <= cx;
                    pix_y     <= cy;
                    pix_depth <= zflat;
                    pix_color <= vc[0];
                end
                if (!last_pos) begin
                    if (cx == xmax) begin
                        cx <= xmin;
                        cy <= cy + COORD_W'(1);
                    end else begin
                        cx <= cx + COORD_W'(1);
                    end
                end
            end
        end
    end
endmodule

// File: doc/raster_scan.md
# raster_scan

Triangle rasterizer, directly downstream of the vertex controller. Latches one screen-space triangle on `vertice_ready`, computes a clamped bounding box and signed area, then scans the box in raster order. It tests each pixel with three edge functions and emits covered pixels over a valid/ready stream toward the depth-test/framebuffer stage. When the triangle is exhausted it pulses `get_next_triangle` back to the controller.

## Interface
- SCREEN_W, 640, horizontal resolution; pixels with x ≥ SCREEN_W are never emitted
- SCREEN_H, 480, vertical resolution; pixels with y ≥ SCREEN_H are never emitted
- clk  in  1  clock
- rst  in  1  reset; one clock, asynchronous, active-high
- vertice_ready  in  1  one-cycle pulse: triangle inputs valid this cycle
- vertice{1,2,3}_x  in  12  vertex x, unsigned screen coordinate
- vertice{1,2,3}_y  in  12  vertex y, unsigned
- vertice{1,2,3}_depth  in  21  vertex depth, unsigned (smaller = nearer)
- vertice{1,2,3}_color  in  24  vertex RGB888
- get_next_triangle  out  1  one-cycle pulse: triangle finished, ready for next
- busy  out  1  high from the cycle after an accepted `vertice_ready` until the `get_next_triangle` pulse, inclusive
- pix_valid  out  1  pixel output valid
- pix_ready  in  1  downstream accepts the pixel
- pix_x  out  12  pixel x
- pix_y  out  12  pixel y
- pix_depth  out  21  pixel depth
- pix_color  out  24  pixel color

## Operation
- FSM states: IDLE, SETUP, SCAN, DRAIN, DONE.
- IDLE
  - `vertice_ready` = 1 latches all 12 vertex fields and moves to SETUP.
  - `vertice_ready` in any other state is ignored.
- SETUP (one cycle)
  - Bounding box: xmin/xmax/ymin/ymax = min/max of the vertex coordinates, clamped to [0, SCREEN_W-1] × [0, SCREEN_H-1].
  - Signed area A = (x2-x1)(y3-y1) - (y2-y1)(x3-x1). Differences are 13-bit signed, products 26-bit, A is 27-bit signed.
  - Flat attributes: depth = min of the three depths; color = vertice1_color.
  - If A = 0, or vmin_x ≥ SCREEN_W, or vmin_y ≥ SCREEN_H: go to DONE. Otherwise go to SCAN with (x,y) = (xmin,ymin).
- SCAN
  - Edge functions at (x,y): E0 = (x2-x1)(y-y1) - (y2-y1)(x-x1); E1 and E2 cyclically for edges v2→v3 and v3→v1. Each is 27-bit signed.
  - Covered = all Ei ≥ 0 when A > 0; all Ei ≤ 0 when A < 0. Edges are inclusive (no top-left rule), so both windings give identical coverage.
  - The scan position advances only when the output register is free: !pix_valid || pix_ready.
  - A covered position loads the output register and raises pix_valid. An uncovered position still costs one cycle.
  - Order: x increments; at xmax, x ← xmin and y increments. The position after (xmax,ymax) goes to DRAIN.
- DRAIN: wait until !pix_valid || pix_ready, then go to DONE.
- DONE: `get_next_triangle` = 1 for exactly one cycle, then IDLE.
- Output stream: while pix_valid = 1 && pix_ready = 0, all pix_* are held stable. No pixel is dropped or duplicated.

## Timing
- Reset values: all outputs 0; FSM in IDLE; latched vertices 0.
- rst asserted mid-triangle: the pending pixel is discarded, no `get_next_triangle` is issued, and the next `vertice_ready` after deassertion is served normally.
- `vertice_ready` is sampled at edge T. SETUP runs in cycle T+1, and the first scan position is evaluated in cycle T+2.
- If that first position is covered, pix_valid is visible in cycle T+3.
- Latency with pix_ready held at 1:
  - Scan covers N = (xmax-xmin+1)(ymax-ymin+1) positions, one per cycle.
  - `get_next_triangle` is high in cycle T+N+3 (DRAIN takes one cycle, DONE the next).
- Degenerate or off-screen triangle: no pixels; `get_next_triangle` is high in cycle T+2.
- Each accepted triangle produces exactly one `get_next_triangle` pulse.

## Structure
- Shared package raster_pkg:
  - width constants: COORD_W=12, DEPTH_W=21, COLOR_W=24, EDGE_W=27
  - FSM state enum
- Sub-module edge_eval: combinational, one edge function. Inputs: two vertices and the (x,y) point. Output: the 27-bit signed Ei. Instantiated three times in SCAN; SETUP reuses instance 0 to compute A.

## Test plan
- Triangle (0,0),(3,0),(0,3), depths 50/20/90, v1 color 0xFF0000, pix_ready=1
  - 10 pixels where x+y ≤ 3, in raster order (0,0),(1,0),(2,0),(3,0),(0,1)…(0,3)
  - every pixel: depth 20, color 0xFF0000
  - `get_next_triangle` once, in cycle T+19
- Same triangle with v2 and v3 swapped (opposite winding) → identical 10 pixels and identical timing.
- Collinear (0,0),(1,1),(2,2) → no pix_valid; `get_next_triangle` in cycle T+2; busy high only in cycles T+1..T+2.
- Backpressure: first triangle, pix_ready low for 5 cycles starting with the first pixel
  - pix_* held constant throughout the stall
  - 10 unique pixels in total
  - `get_next_triangle` delayed by exactly 5 cycles
- Clamp: (630,0),(700,0),(630,20) with SCREEN_W=640 → every emitted pix_x is in 630..639, none ≥ 640; scan is bounded to the 10×21 box.
- Assert rst during SCAN of the first triangle
  - all outputs 0 next cycle; no `get_next_triangle` pulse
  - a following (0,0),(3,0),(0,3) triangle yields the 10 pixels of the first scenario.
